mpu_sequencer: RTL and testbench
================================

// Module: mpu_sequencer
// PURPOSE
//  Instruction sequencer for the 4-bit MPU datapath. Accepts 8-bit encoded instructions over a
//  valid/ready stream and issues registered datapath control words (clr/ce/w/sel/s), one per cycle.
//  Sits between the program source and the datapath, replacing the fixed-sequence FSM.
//  Handles multi-cycle MOVM, CLR, HALT/resume and illegal-opcode trapping.
// PARAMETERS
//  CNT_W        8  width of the retire counter (only with MPU_SEQ_RETIRE_CNT_EN)
//  HALT_ON_ERR  1  1: illegal opcode enters HALTED; 0: treated as NOP, err_o still set
// PORTS
//  clk          in   1  clock; all state updates on rising edge
//  reset        in   1  asynchronous, active-low reset
//  instr_i      in   8  {op[7:5], dest[4:3], src[2:0]}
//  instr_valid_i in  1  instr_i valid
//  instr_ready_o out 1  sequencer accepts instr_i this cycle
//  resume_i     in   1  leave HALTED (level sampled per cycle)
//  clr_o        out  1  datapath clear, 1-cycle pulse
//  ce_o         out  4  register clock enables {A,R2,R1,R0}, at most one bit set
//  w_o          out  3  RX register input mux select (source code)
//  sel_o        out  2  ALU B mux select (0=R0,1=R1,2=R2,3=A)
//  s_o          out  3  ALU opcode (000 pass-B, 001 ADC, 010 SBC)
//  busy_o       out  1  state != IDLE
//  halted_o     out  1  state == HALTED
//  err_o        out  1  sticky illegal-opcode flag
// BEHAVIOUR
//  - Reset (async, active-low): state=IDLE; all outputs 0 except instr_ready_o=0 until first clk edge.
//  - Opcodes: 000 NOP, 001 MOV dest,src, 010 MOVM, 011 ADC src, 100 SBC src, 101 CLR, 111 HALT,
//    110 illegal. dest: 0..2=R0..R2, 3=A. src: 0..2=R0..R2, 3=A, 4..6=M0..M2, 7=Cin.
//  - Accept when instr_valid_i & instr_ready_o. Controls for an accepted instr appear, registered,
//    the following cycle; all controls are 0 in any cycle with no issue (no held enables).
//  - States: IDLE, EXEC, MOVM1, MOVM2, HALTED. instr_ready_o=1 in IDLE and EXEC only.
//    IDLE/EXEC --accept single-cycle op--> EXEC (issue); no accept -> IDLE.
//    accept MOVM -> MOVM1: issue ce=0001,w=4; then MOVM2: ce=0010,w=5; then ce=0100,w=6 -> IDLE.
//    accept HALT -> HALTED (no controls); HALTED & resume_i -> IDLE next cycle.
//  - MOV dest=R0..R2: ce one-hot dest, w=src. MOV dest=A: ce=1000, sel=src[1:0], s=000;
//    MOV A with src>=4 is illegal. ADC/SBC: ce=1000, sel=src[1:0], s=001/010; src>=4 illegal.
//  - CLR: clr_o=1 for exactly one cycle, ce=0000.
//  - Illegal: err_o<=1 (sticky until reset); HALT_ON_ERR=1 -> HALTED, else behaves as NOP.
//  - instr_valid_i during MOVM1/MOVM2/HALTED: held, not accepted (ready=0); source must hold instr_i.
//  - resume_i while not HALTED: ignored. resume_i and instr_valid_i in HALTED: resume wins, instr
//    accepted no earlier than the IDLE cycle.
//  - Reset mid-MOVM: sequence abandoned, remaining enables never issued.
// CONFIGURATION
//  MPU_SEQ_RETIRE_CNT_EN defined: adds output retired_o [CNT_W-1:0], +1 per completed instruction
//  (MOVM counts once at final beat; NOP counts; illegal/HALT do not), wraps 2^CNT_W-1 -> 0, reset 0.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  mpu_pkg: op_e, dest/src codes, state_e, ctrl_t struct {clr, ce, w, sel, s}, ALU opcode constants.
//  Sub-module mpu_seq_decode: combinational instr -> {ctrl_t, illegal, multi_cycle}; top holds FSM,
//  output register and counter.
// TESTING
//  1 Reset low mid-MOVM (after MOVM1) -> all outputs 0 immediately; after release ready=1, ce never 0100.
//  2 MOV R1,M2 (0x2E) accepted -> next cycle ce=0010,w=6, then ce=0000 if no further valid.
//  3 Back-to-back ADC R2 (0x62), SBC A (0x83) -> ce=1000,sel=2,s=001 then ce=1000,sel=3,s=010.
//  4 MOVM (0x40) with valid held high -> ready 0 for 2 cycles, ce 0001/0010/0100, w 4/5/6.
//  5 Opcode 110 (0xC0), HALT_ON_ERR=1 -> err_o=1, halted_o=1; resume_i -> IDLE, err_o stays 1.
//  6 RETIRE_CNT_EN, CNT_W=2: five NOPs -> retired_o 1,2,3,0,1; HALT (0xE0) leaves count unchanged.

Source files
------------

// File: rtl/mpu_pkg.sv
// mpu_pkg: opcodes, field codes, FSM states and the control word for mpu_sequencer.
// Optional retire counter in the sequencer is enabled by MPU_SEQ_RETIRE_CNT_EN.
package mpu_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_MOV  = 3'b001,
        OP_MOVM = 3'b010,
        OP_ADC  = 3'b011,
        OP_SBC  = 3'b100,
        OP_CLR  = 3'b101,
        OP_ILL  = 3'b110,
        OP_HALT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        DEST_R0 = 2'd0,
        DEST_R1 = 2'd1,
        DEST_R2 = 2'd2,
        DEST_A  = 2'd3
    } dest_e;

    // First memory source code; M0..M2 follow it.
    localparam logic [2:0] SRC_M0 = 3'd4;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADC    = 3'b001;
    localparam logic [2:0] ALU_SBC    = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXEC   = 3'd1,
        S_MOVM1  = 3'd2,
        S_MOVM2  = 3'd3,
        S_HALTED = 3'd4
    } state_e;

    typedef struct packed {
        logic       clr;
        logic [3:0] ce;
        logic [2:0] w;
        logic [1:0] sel;
        logic [2:0] s;
    } ctrl_t;

    // MOVM beat n loads Rn from Mn.
    function automatic ctrl_t movm_beat(input logic [1:0] idx);
        ctrl_t c;
        c    = '0;
        c.ce = 4'b0001 << idx;
        c.w  = SRC_M0 + {1'b0, idx};
        return c;
    endfunction

endpackage

// File: rtl/mpu_sequencer_if.sv
// mpu_sequencer_if: valid/ready instruction stream into the sequencer.
// master = program source, slave = sequencer.
interface mpu_sequencer_if;
    logic [7:0] instr_i;
    logic       instr_valid_i;
    logic       instr_ready_o;

    modport master (
        output instr_i,
        output instr_valid_i,
        input  instr_ready_o
    );

    modport slave (
        input  instr_i,
        input  instr_valid_i,
        output instr_ready_o
    );
endinterface

// File: rtl/mpu_seq_decode.sv
// mpu_seq_decode: combinational instruction decode to first-cycle controls.
// Illegal forms decode to an all-zero control word.
module mpu_seq_decode
    import mpu_pkg::*;
(
    input  logic [7:0] instr,
    output ctrl_t      ctrl,
    output logic       illegal,
    output logic       multi_cycle,
    output logic       halt
);

    op_e        op;
    dest_e      dest;
    logic [2:0] src;
    logic       src_ext;

    assign op      = op_e'(instr[7:5]);
    assign dest    = dest_e'(instr[4:3]);
    assign src     = instr[2:0];
    // M0..M2 and Cin cannot feed the ALU B mux.
    assign src_ext = src[2];

    // Map one instruction to its control word and class flags.
    always_comb begin
        ctrl        = '0;
        illegal     = 1'b0;
        multi_cycle = 1'b0;
        halt        = 1'b0;
        unique case (1'b1)
            (op == OP_NOP): begin
            end
            (op == OP_MOV): begin
                if (dest != DEST_A) begin
                    ctrl.ce = 4'b0001 << dest;
                    ctrl.w  = src;
                end else if (src_ext) begin
                    illegal = 1'b1;
                end else begin
                    ctrl.ce  = 4'b1000;
                    ctrl.sel = src[1:0];
                    ctrl.s   = ALU_PASS_B;
                end
            end
            (op == OP_MOVM): begin
                multi_cycle = 1'b1;
                ctrl        = movm_beat(2'd0);
            end
            (op == OP_ADC), (op == OP_SBC): begin
                if (src_ext) begin
                    illegal = 1'b1;
                end else begin
                    ctrl.ce  = 4'b1000;
                    ctrl.sel = src[1:0];
                    ctrl.s   = (op == OP_ADC) ? ALU_ADC : ALU_SBC;
                end
            end
            (op == OP_CLR): begin
                ctrl.clr = 1'b1;
            end
            (op == OP_HALT): begin
                halt = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mpu_sequencer.sv
// mpu_sequencer: issues one registered datapath control word per cycle.
// Define MPU_SEQ_RETIRE_CNT_EN to add the retired_o instruction counter.
module mpu_sequencer
    import mpu_pkg::*;
#(
    parameter bit HALT_ON_ERR = 1'b1
`ifdef MPU_SEQ_RETIRE_CNT_EN
    ,
    parameter int CNT_W       = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    mpu_sequencer_if.slave   instr_if,
    input  logic             resume_i,
    output logic             clr_o,
    output logic [3:0]       ce_o,
    output logic [2:0]       w_o,
    output logic [1:0]       sel_o,
    output logic [2:0]       s_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic             err_o
`ifdef MPU_SEQ_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_o
`endif
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;
    ctrl_t  dec_ctrl;
    logic   dec_illegal;
    logic   dec_multi;
    logic   dec_halt;
    logic   started_q;
    logic   err_q;
    logic   accept;
    logic   stop;

    mpu_seq_decode u_decode (
        .instr       (instr_if.instr_i),
        .ctrl        (dec_ctrl),
        .illegal     (dec_illegal),
        .multi_cycle (dec_multi),
        .halt        (dec_halt)
    );

    // ready stays low until the first edge after reset release
    assign instr_if.instr_ready_o = started_q &&
        (state_q == S_IDLE || state_q == S_EXEC);
    assign accept = instr_if.instr_valid_i & instr_if.instr_ready_o;
    assign stop   = dec_halt | (dec_illegal & HALT_ON_ERR);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: single ops run in EXEC, MOVM walks two extra beats.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_EXEC: begin
                if (!accept)        state_d = S_IDLE;
                else if (dec_multi) state_d = S_MOVM1;
                else if (stop)      state_d = S_HALTED;
                else                state_d = S_EXEC;
            end
            S_MOVM1:  state_d = S_MOVM2;
            S_MOVM2:  state_d = S_IDLE;
            S_HALTED: if (resume_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode: control word to register for the next cycle.
    always_comb begin
        ctrl_d = '0;
        unique case (state_q)
            S_IDLE, S_EXEC: if (accept) ctrl_d = dec_ctrl;
            S_MOVM1:        ctrl_d = movm_beat(2'd1);
            S_MOVM2:        ctrl_d = movm_beat(2'd2);
            default:        ctrl_d = '0;
        endcase
    end

    // Output register, ready gate and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= '0;
            started_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            started_q <= 1'b1;
            err_q     <= err_q | (accept & dec_illegal);
        end
    end

    assign clr_o    = ctrl_q.clr;
    assign ce_o     = ctrl_q.ce;
    assign w_o      = ctrl_q.w;
    assign sel_o    = ctrl_q.sel;
    assign s_o      = ctrl_q.s;
    assign busy_o   = (state_q != S_IDLE);
    assign halted_o = (state_q == S_HALTED);
    assign err_o    = err_q;

`ifdef MPU_SEQ_RETIRE_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] cnt_q;

    // MOVM retires on its last beat; HALT and illegal never retire.
    assign retire = (accept & ~dec_multi & ~dec_halt & ~dec_illegal) |
                    (state_q == S_MOVM2);

    // Retire counter, aligned with the issued control word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      cnt_q <= '0;
        else if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign retired_o = cnt_q;
`endif

endmodule

// File: tb/tb_mpu_sequencer.sv
// tb_mpu_sequencer: directed plus random stimulus against a beat-queue model.
// Retire counter checks are active when MPU_SEQ_RETIRE_CNT_EN is defined.
module tb_mpu_sequencer;

    localparam bit HOE = 1'b1;
`ifdef MPU_SEQ_RETIRE_CNT_EN
    localparam int CW = 2;
`endif

    typedef struct packed {
        logic       clr;
        logic [3:0] ce;
        logic [2:0] w;
        logic [1:0] sel;
        logic [2:0] s;
        logic       retire;
        logic       single;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       resume;
    logic       clr;
    logic [3:0] ce;
    logic [2:0] w;
    logic [1:0] sel;
    logic [2:0] s;
    logic       busy;
    logic       halted;
    logic       err;
`ifdef MPU_SEQ_RETIRE_CNT_EN
    logic [CW-1:0] retired;
`endif

    beat_t m_q[$];
    beat_t m_cur;
    bit    m_halted;
    bit    m_err;
    bit    m_ready;
    bit    m_busy;
    int    m_cnt;
    bit    last_acc;
    int    total;
    int    bad;

    mpu_sequencer_if sif ();

    mpu_sequencer #(
        .HALT_ON_ERR (HOE)
`ifdef MPU_SEQ_RETIRE_CNT_EN
        ,
        .CNT_W       (CW)
`endif
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .instr_if  (sif),
        .resume_i  (resume),
        .clr_o     (clr),
        .ce_o      (ce),
        .w_o       (w),
        .sel_o     (sel),
        .s_o       (s),
        .busy_o    (busy),
        .halted_o  (halted),
        .err_o     (err)
`ifdef MPU_SEQ_RETIRE_CNT_EN
        ,
        .retired_o (retired)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur    = '0;
        m_halted = 1'b0;
        m_err    = 1'b0;
        m_ready  = 1'b0;
        m_busy   = 1'b0;
        m_cnt    = 0;
    endtask

    // Expand one accepted instruction into the beats it must produce.
    task automatic model_accept(input logic [7:0] ins);
        logic [2:0] op;
        logic [1:0] d;
        logic [2:0] sr;
        bit         ill;
        beat_t      b;
        op  = ins[7:5];
        d   = ins[4:3];
        sr  = ins[2:0];
        ill = 1'b0;
        b   = '0;
        b.single = 1'b1;
        case (op)
            3'd0: b.retire = 1'b1;
            3'd1: begin
                if (d != 2'd3) begin
                    b.ce = 4'b0001 << d;
                    b.w  = sr;
                    b.retire = 1'b1;
                end else if (sr >= 3'd4) begin
                    ill = 1'b1;
                end else begin
                    b.ce  = 4'b1000;
                    b.sel = sr[1:0];
                    b.retire = 1'b1;
                end
            end
            3'd2: begin
                for (int k = 0; k < 3; k++) begin
                    beat_t nb;
                    nb = '0;
                    nb.ce = 4'b0001 << k;
                    nb.w  = 3'(4 + k);
                    nb.retire = (k == 2);
                    m_q.push_back(nb);
                end
                return;
            end
            3'd3, 3'd4: begin
                if (sr >= 3'd4) begin
                    ill = 1'b1;
                end else begin
                    b.ce  = 4'b1000;
                    b.sel = sr[1:0];
                    b.s   = (op == 3'd3) ? 3'b001 : 3'b010;
                    b.retire = 1'b1;
                end
            end
            3'd5: begin
                b.clr = 1'b1;
                b.retire = 1'b1;
            end
            3'd6: ill = 1'b1;
            default: m_halted = 1'b1;
        endcase
        if (ill) begin
            m_err = 1'b1;
            if (HOE) m_halted = 1'b1;
        end
        m_q.push_back(b);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".clr"}, 32'(clr), 32'(m_cur.clr));
        check({tag, ".ce"}, 32'(ce), 32'(m_cur.ce));
        check({tag, ".w"}, 32'(w), 32'(m_cur.w));
        check({tag, ".sel"}, 32'(sel), 32'(m_cur.sel));
        check({tag, ".s"}, 32'(s), 32'(m_cur.s));
        check({tag, ".ready"}, 32'(sif.instr_ready_o), 32'(m_ready));
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
        check({tag, ".halted"}, 32'(halted), 32'(m_halted));
        check({tag, ".err"}, 32'(err), 32'(m_err));
`ifdef MPU_SEQ_RETIRE_CNT_EN
        check({tag, ".ret"}, 32'(retired), 32'(m_cnt % (1 << CW)));
`endif
    endtask

    // Advance one clock, update the model, compare #1 after the edge.
    task automatic cyc(input string tag);
        bit         acc;
        bit         res;
        logic [7:0] ins;
        acc = sif.instr_valid_i && m_ready;
        res = resume;
        ins = sif.instr_i;
        @(posedge clk);
        last_acc = acc;
        m_halted = m_halted && !res;
        if (acc) model_accept(ins);
        m_cur = (m_q.size() != 0) ? m_q.pop_front() : beat_t'('0);
        m_cnt += int'(m_cur.retire);
        m_ready = !m_halted && (m_q.size() == 0);
        m_busy  = m_halted || (m_q.size() != 0) || m_cur.single;
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [7:0] ins, input logic vld);
        sif.instr_i       = ins;
        sif.instr_valid_i = vld;
    endtask

`ifdef MPU_SEQ_RETIRE_CNT_EN
    int exp_r[5] = '{1, 2, 3, 0, 1};
`endif

    initial begin
        total    = 0;
        bad      = 0;
        last_acc = 1'b0;
        rst_n    = 1'b0;
        resume   = 1'b0;
        drive(8'h00, 1'b0);
        model_reset();

        #3;
        check_all("rst");
        check("rst.ready0", 32'(sif.instr_ready_o), 32'd0);
        #10;
        rst_n = 1'b1;
        #1;
        check("rel.ready0", 32'(sif.instr_ready_o), 32'd0);
        cyc("first");
        check("first.ready1", 32'(sif.instr_ready_o), 32'd1);

        drive(8'h2E, 1'b1);
        cyc("mov");
        check("mov.ce", 32'(ce), 32'b0010);
        check("mov.w", 32'(w), 32'd6);
        drive(8'h00, 1'b0);
        cyc("mov_gap");
        check("mov_gap.ce", 32'(ce), 32'd0);

        drive(8'h62, 1'b1);
        cyc("adc");
        check("adc.ce", 32'(ce), 32'b1000);
        check("adc.sel", 32'(sel), 32'd2);
        check("adc.s", 32'(s), 32'b001);
        drive(8'h83, 1'b1);
        cyc("sbc");
        check("sbc.ce", 32'(ce), 32'b1000);
        check("sbc.sel", 32'(sel), 32'd3);
        check("sbc.s", 32'(s), 32'b010);

        drive(8'h40, 1'b1);
        cyc("movm0");
        check("movm0.ce", 32'(ce), 32'b0001);
        check("movm0.ready", 32'(sif.instr_ready_o), 32'd0);
        cyc("movm1");
        check("movm1.ce", 32'(ce), 32'b0010);
        check("movm1.ready", 32'(sif.instr_ready_o), 32'd0);
        drive(8'h40, 1'b0);
        cyc("movm2");
        check("movm2.ce", 32'(ce), 32'b0100);
        check("movm2.w", 32'(w), 32'd6);

        drive(8'hA0, 1'b1);
        cyc("clr");
        check("clr.pulse", 32'(clr), 32'd1);
        drive(8'h00, 1'b0);
        cyc("clr_end");
        check("clr_end.pulse", 32'(clr), 32'd0);

        drive(8'hC0, 1'b1);
        cyc("ill");
        check("ill.err", 32'(err), 32'd1);
        check("ill.halted", 32'(halted), 32'd1);
        drive(8'h62, 1'b1);
        resume = 1'b1;
        cyc("resume");
        check("resume.halted", 32'(halted), 32'd0);
        check("resume.ce", 32'(ce), 32'd0);
        resume = 1'b0;
        cyc("post_res");
        check("post_res.ce", 32'(ce), 32'b1000);
        check("post_res.err", 32'(err), 32'd1);
        drive(8'h00, 1'b0);
        resume = 1'b1;
        cyc("res_ign");
        resume = 1'b0;

        drive(8'h40, 1'b1);
        cyc("mr0");
        drive(8'h40, 1'b0);
        cyc("mr1");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mrst");
        check("mrst.ce", 32'(ce), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc("after_mrst");
            check("after_mrst.no0100", 32'(ce == 4'b0100), 32'd0);
        end
        check("after_mrst.ready", 32'(sif.instr_ready_o), 32'd1);

        drive(8'h00, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc("nop");
`ifdef MPU_SEQ_RETIRE_CNT_EN
            check("nop.ret", 32'(retired), 32'(exp_r[k]));
`endif
        end
        drive(8'hE0, 1'b1);
        cyc("halt");
        check("halt.halted", 32'(halted), 32'd1);
`ifdef MPU_SEQ_RETIRE_CNT_EN
        check("halt.ret", 32'(retired), 32'd1);
`endif
        drive(8'h00, 1'b0);
        resume = 1'b1;
        cyc("halt_res");
        resume = 1'b0;

        for (int i = 0; i < 600; i++) begin
            if (!(sif.instr_valid_i && !last_acc)) begin
                drive(8'($urandom), $urandom_range(0, 3) != 0);
            end
            resume = ($urandom_range(0, 2) == 0);
            cyc("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
